block_rotate_4x4: RTL and testbench

- Sits directly downstream of the 4-row line-to-column stage.
- Consumes its 64-bit column words: each word is one column of a 4-row band, 4 pixels of RGB565.
- Groups every 4 consecutive column words into one 4x4 pixel block and rotates the block by 0/90/180/270 degrees.
- Emits the rotated block as 4 row words with block coordinates for the DDR write address generator.
- Ping-pong storage lets input stream continuously while the previous block drains.

---
 rtl/block_rotate_4x4_pkg.sv | 30 +++
 rtl/block_rotate_4x4_if.sv | 32 +++
 rtl/block_rotate_4x4_rot_mux.sv | 33 +++
 rtl/block_rotate_4x4.sv | 211 +++++++++++++++++++++
 tb/tb_block_rotate_4x4.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/block_rotate_4x4_pkg.sv
// Shared types and constants for the 4x4 block rotator: rotation codes, pixel
// geometry and the output FSM encoding.
package block_rotate_4x4_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned BLK_N  = 4;
  localparam int unsigned WORD_W = PIX_W * BLK_N;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // One stored block: BLK_N column words, index = column slot
  typedef logic [BLK_N-1:0][WORD_W-1:0] blk_t;

  // Index counted from the opposite edge of the block
  function automatic logic [IDX_W-1:0] mirror_idx(input logic [IDX_W-1:0] i);
    return IDX_W'(BLK_N - 1) - i;
  endfunction

endpackage

// File: rtl/block_rotate_4x4_if.sv
// Column-word input, rotated-row output and frame control of the block rotator.
interface block_rotate_4x4_if
  import block_rotate_4x4_pkg::*;
#(
  parameter int unsigned BLK_X_W = 9,
  parameter int unsigned BLK_Y_W = 9
);

  logic               sof;
  logic [1:0]         rot;
  logic               in_en;
  logic [WORD_W-1:0]  in_col;
  logic               out_ready;
  logic               out_valid;
  logic [WORD_W-1:0]  out_word;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic [BLK_X_W-1:0] blk_x;
  logic [BLK_Y_W-1:0] blk_y;
  logic               overflow;

  modport master (
    output sof, rot, in_en, in_col, out_ready,
    input  out_valid, out_word, out_idx, out_last, blk_x, blk_y, overflow
  );

  modport slave (
    input  sof, rot, in_en, in_col, out_ready,
    output out_valid, out_word, out_idx, out_last, blk_x, blk_y, overflow
  );

endinterface

// File: rtl/block_rotate_4x4_rot_mux.sv
// Combinational selector: one rotated output row of a stored 4x4 block.
// Pixel P[r][c] is row r of column word c; output row idx_i, pixel j.
module block_rot_mux
  import block_rotate_4x4_pkg::*;
(
  input  blk_t              bank_i,
  input  rot_e              rot_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] row_c
);

  logic [IDX_W-1:0] jj;
  logic [IDX_W-1:0] r;
  logic [IDX_W-1:0] c;

  always_comb begin
    row_c = '0;
    jj    = '0;
    r     = '0;
    c     = '0;
    for (int j = 0; j < int'(BLK_N); j++) begin
      jj = IDX_W'(j);
      case (rot_i)
        ROT_90:  begin r = mirror_idx(jj);    c = idx_i;             end
        ROT_180: begin r = mirror_idx(idx_i); c = mirror_idx(jj);    end
        ROT_270: begin r = jj;                c = mirror_idx(idx_i); end
        default: begin r = idx_i;             c = jj;                end
      endcase
      row_c[(BLK_N-1-j)*PIX_W +: PIX_W] = bank_i[c][(BLK_N-1-int'(r))*PIX_W +: PIX_W];
    end
  end

endmodule

// File: rtl/block_rotate_4x4.sv
// Groups 4 column words into a 4x4 RGB565 block, rotates it and streams it out
// as 4 row words; two banks let the next block fill while the current drains.
module block_rotate_4x4
  import block_rotate_4x4_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 1280,
  parameter int unsigned BLK_X_W   = 9,
  parameter int unsigned BLK_Y_W   = 9
) (
  input logic               pclk,
  input logic               rst,
  block_rotate_4x4_if.slave bus
);

  localparam int unsigned        BLK_PER_LINE = LINE_SIZE / BLK_N;
  localparam logic [BLK_X_W-1:0] X_LAST       = BLK_X_W'(BLK_PER_LINE - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(BLK_N - 1);

  blk_t [1:0]         bank_q;
  logic [1:0]         full_q, full_d;
  rot_e               rot_lat_q [2], rot_lat_d [2];
  logic [BLK_X_W-1:0] x_lat_q [2], x_lat_d [2];
  logic [BLK_Y_W-1:0] y_lat_q [2], y_lat_d [2];
  logic               wbank_q, wbank_d;
  logic [IDX_W-1:0]   wcol_q, wcol_d;
  logic [BLK_X_W-1:0] in_x_q, in_x_d;
  logic [BLK_Y_W-1:0] in_y_q, in_y_d;
  state_e             state_q, state_d;
  logic               rbank_q, rbank_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [BLK_X_W-1:0] bx_q, bx_d;
  logic [BLK_Y_W-1:0] by_q, by_d;
  logic               ovf_q, ovf_d;

  logic               xfer_c, free_c, wr_fire_c, sel_bank_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic [WORD_W-1:0]  row_c;

  // A bank whose last row leaves this cycle may be refilled in the same cycle
  assign xfer_c    = (state_q == ST_SEND) && valid_q && bus.out_ready;
  assign free_c    = xfer_c && (idx_q == IDX_LAST);
  assign wr_fire_c = bus.in_en && !(full_q[wbank_q] && !(free_c && (rbank_q == wbank_q)));

  // Row that will be presented after this cycle
  always_comb begin
    sel_bank_c = rbank_q;
    sel_idx_c  = '0;
    if (free_c)                    sel_bank_c = ~rbank_q;
    else if (state_q == ST_SEND)   sel_idx_c  = idx_q + IDX_W'(1);
  end

  block_rot_mux u_rot_mux (
    .bank_i (bank_q[sel_bank_c]),
    .rot_i  (rot_lat_q[sel_bank_c]),
    .idx_i  (sel_idx_c),
    .row_c  (row_c)
  );

  always_comb begin
    full_d    = full_q;
    rot_lat_d = rot_lat_q;
    x_lat_d   = x_lat_q;
    y_lat_d   = y_lat_q;
    wbank_d   = wbank_q;
    wcol_d    = wcol_q;
    in_x_d    = in_x_q;
    in_y_d    = in_y_q;
    state_d   = state_q;
    rbank_d   = rbank_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    word_d    = word_q;
    last_d    = last_q;
    bx_d      = bx_q;
    by_d      = by_q;
    ovf_d     = ovf_q;

    if (bus.in_en && !wr_fire_c) ovf_d = 1'b1;
    if (wr_fire_c) begin
      wcol_d = wcol_q + IDX_W'(1);
      if (wcol_q == IDX_LAST) begin
        full_d[wbank_q]    = 1'b1;
        rot_lat_d[wbank_q] = rot_e'(bus.rot);
        x_lat_d[wbank_q]   = in_x_q;
        y_lat_d[wbank_q]   = in_y_q;
        wbank_d            = ~wbank_q;
        if (in_x_q == X_LAST) begin
          in_x_d = '0;
          in_y_d = in_y_q + BLK_Y_W'(1);
        end else begin
          in_x_d = in_x_q + BLK_X_W'(1);
        end
      end
    end
    if (free_c) full_d[rbank_q] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          idx_d   = '0;
          last_d  = 1'b0;
          word_d  = row_c;
          bx_d    = x_lat_q[rbank_q];
          by_d    = y_lat_q[rbank_q];
        end
      end
      ST_SEND: begin
        if (xfer_c) begin
          if (idx_q != IDX_LAST) begin
            idx_d  = sel_idx_c;
            last_d = (sel_idx_c == IDX_LAST);
            word_d = row_c;
          end else begin
            rbank_d = ~rbank_q;
            idx_d   = '0;
            last_d  = 1'b0;
            if (full_q[~rbank_q]) begin
              word_d = row_c;
              bx_d   = x_lat_q[~rbank_q];
              by_d   = y_lat_q[~rbank_q];
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start of frame discards everything, including a partial block
    if (bus.sof) begin
      full_d    = '0;
      rot_lat_d = '{default: ROT_0};
      x_lat_d   = '{default: '0};
      y_lat_d   = '{default: '0};
      wbank_d   = 1'b0;
      wcol_d    = '0;
      in_x_d    = '0;
      in_y_d    = '0;
      state_d   = ST_IDLE;
      rbank_d   = 1'b0;
      idx_d     = '0;
      valid_d   = 1'b0;
      word_d    = '0;
      last_d    = 1'b0;
      bx_d      = '0;
      by_d      = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      rot_lat_q <= '{default: ROT_0};
      x_lat_q   <= '{default: '0};
      y_lat_q   <= '{default: '0};
      wbank_q   <= 1'b0;
      wcol_q    <= '0;
      in_x_q    <= '0;
      in_y_q    <= '0;
      state_q   <= ST_IDLE;
      rbank_q   <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      word_q    <= '0;
      last_q    <= 1'b0;
      bx_q      <= '0;
      by_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      rot_lat_q <= rot_lat_d;
      x_lat_q   <= x_lat_d;
      y_lat_q   <= y_lat_d;
      wbank_q   <= wbank_d;
      wcol_q    <= wcol_d;
      in_x_q    <= in_x_d;
      in_y_q    <= in_y_d;
      state_q   <= state_d;
      rbank_q   <= rbank_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      word_q    <= word_d;
      last_q    <= last_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      ovf_q     <= ovf_d;
    end
  end

  // Pixel storage needs no reset: the full flags decide what is valid
  always_ff @(posedge pclk) begin
    if (wr_fire_c && !bus.sof) bank_q[wbank_q][wcol_q] <= bus.in_col;
  end

  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.blk_x     = bx_q;
  assign bus.blk_y     = by_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_block_rotate_4x4.sv
// Randomised bench for block_rotate_4x4 against a block-queue reference model
// that rotates a 4x4 pixel matrix by repeated quarter turns.
module tb_block_rotate_4x4;
  import block_rotate_4x4_pkg::*;

  localparam int unsigned LINE_SIZE = 1280;
  localparam int unsigned BLK_X_W   = 9;
  localparam int unsigned BLK_Y_W   = 9;
  localparam int          BPL       = int'(LINE_SIZE / 4);

  typedef struct packed {
    logic [3:0][63:0]   c;
    logic [1:0]         rot;
    logic [BLK_X_W-1:0] bx;
    logic [BLK_Y_W-1:0] by;
  } mblk_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  block_rotate_4x4_if #(.BLK_X_W(BLK_X_W), .BLK_Y_W(BLK_Y_W)) bus ();

  block_rotate_4x4 #(
    .LINE_SIZE (LINE_SIZE),
    .BLK_X_W   (BLK_X_W),
    .BLK_Y_W   (BLK_Y_W)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_xfer = 0, first_xfer = -1, last_xfer = -1;

  mblk_t            stored [$];
  logic [3:0][63:0] part;
  int               pcount, drained, blk_n;
  bit               ovf_m;
  logic [63:0]      first_word, last_word;
  logic [BLK_X_W-1:0] first_bx;
  logic [BLK_Y_W-1:0] first_by;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected output row i: quarter-turn the pixel matrix clockwise rot times
  function automatic logic [63:0] exp_row(input mblk_t b, input int i);
    logic [15:0] m [4][4];
    logic [15:0] t [4][4];
    logic [63:0] row;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = b.c[c][63-16*r -: 16];
    for (int k = 0; k < int'(b.rot); k++) begin
      t = m;
      for (int a = 0; a < 4; a++)
        for (int j = 0; j < 4; j++)
          m[a][j] = t[3-j][a];
    end
    row = '0;
    for (int j = 0; j < 4; j++) row[63-16*j -: 16] = m[i][j];
    return row;
  endfunction

  task automatic model_reset();
    stored.delete();
    part    = '0;
    pcount  = 0;
    drained = 0;
    blk_n   = 0;
    ovf_m   = 1'b0;
  endtask

  // One clock: called at a falling edge, drives inputs, checks, advances the model
  task automatic step(input bit en, input logic [63:0] col, input logic [1:0] r,
                      input bit rdy, input bit s);
    bit    freeing;
    mblk_t nb;
    freeing       = 1'b0;
    bus.in_en     = en;
    bus.in_col    = col;
    bus.rot       = r;
    bus.out_ready = rdy;
    bus.sof       = s;
    if (bus.out_valid) begin
      if (stored.size() == 0) begin
        check("spurious_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        check("out_word", bus.out_word, exp_row(stored[0], drained));
        check("out_idx",  64'(bus.out_idx), 64'(drained));
        check("out_last", 64'(bus.out_last), 64'(drained == 3));
        check("blk_x",    64'(bus.blk_x), 64'(stored[0].bx));
        check("blk_y",    64'(bus.blk_y), 64'(stored[0].by));
        if (rdy) begin
          n_xfer++;
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
          if (drained == 0) begin
            first_word = bus.out_word;
            first_bx   = bus.blk_x;
            first_by   = bus.blk_y;
          end
          if (drained == 3) last_word = bus.out_word;
          drained++;
          if (drained == 4) freeing = 1'b1;
        end
      end
    end
    if (en && !s) begin
      if (pcount == 0 && stored.size() == 2 && !freeing) begin
        ovf_m = 1'b1;
      end else begin
        part[pcount] = col;
        pcount++;
        if (pcount == 4) begin
          nb.c   = part;
          nb.rot = r;
          nb.bx  = BLK_X_W'(blk_n % BPL);
          nb.by  = BLK_Y_W'(blk_n / BPL);
          stored.push_back(nb);
          blk_n++;
          pcount = 0;
        end
      end
    end
    if (freeing) begin
      void'(stored.pop_front());
      drained = 0;
    end
    if (s) model_reset();
    @(posedge pclk);
    @(negedge pclk);
    cyc++;
    check("overflow", 64'(bus.overflow), 64'(ovf_m));
  endtask

  task automatic drain(input int budget, input bit rnd_rdy);
    for (int k = 0; k < budget && stored.size() != 0; k++)
      step(1'b0, '0, 2'd0, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    check("drain_done", 64'(stored.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [63:0] map_cols  [4];
  logic [63:0] map_first [4];

  initial begin
    map_cols[0]  = 64'h0000_0004_0008_000C;
    map_cols[1]  = 64'h0001_0005_0009_000D;
    map_cols[2]  = 64'h0002_0006_000A_000E;
    map_cols[3]  = 64'h0003_0007_000B_000F;
    map_first[0] = 64'h0000_0001_0002_0003;
    map_first[1] = 64'h000C_0008_0004_0000;
    map_first[2] = 64'h000F_000E_000D_000C;
    map_first[3] = 64'h0003_0007_000B_000F;

    bus.sof = 1'b0; bus.rot = 2'd0; bus.in_en = 1'b0;
    bus.in_col = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk);

    check("rst_valid",    64'(bus.out_valid), 64'd0);
    check("rst_word",     bus.out_word,       64'd0);
    check("rst_idx",      64'(bus.out_idx),   64'd0);
    check("rst_last",     64'(bus.out_last),  64'd0);
    check("rst_blk_x",    64'(bus.blk_x),     64'd0);
    check("rst_blk_y",    64'(bus.blk_y),     64'd0);
    check("rst_overflow", 64'(bus.overflow),  64'd0);
    rst = 1'b0;
    @(negedge pclk);

    // Known mapping for each rotation
    for (int rr = 0; rr < 4; rr++) begin
      for (int c = 0; c < 4; c++) step(1'b1, map_cols[c], 2'(rr), 1'b1, 1'b0);
      drain(40, 1'b0);
      check($sformatf("map_rot%0d_first", rr), first_word, map_first[rr]);
      if (rr == 0) check("map_rot0_last", last_word, 64'h000C_000D_000E_000F);
    end

    // Full line plus one block, streaming
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    n_xfer = 0; first_xfer = -1; last_xfer = -1;
    for (int k = 0; k < int'(LINE_SIZE) + 4; k++)
      step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    drain(40, 1'b0);
    check("cont_words",     64'(n_xfer), 64'(LINE_SIZE + 4));
    check("cont_no_bubble", 64'(last_xfer - first_xfer + 1), 64'(LINE_SIZE + 4));
    check("cont_wrap_bx",   64'(first_bx), 64'd0);
    check("cont_wrap_by",   64'(first_by), 64'd1);

    // Backpressure mid-block, then both banks full
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    n_xfer = 0;
    for (int k = 0; k < 10 && n_xfer == 0; k++) step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    check("bp_one_xfer", 64'(n_xfer), 64'd1);
    for (int k = 0; k < 10; k++)
      step(k < 5, rnd64(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    check("bp_overflow", 64'(bus.overflow), 64'd1);
    drain(80, 1'b1);

    // Asynchronous reset during SEND clears sticky overflow
    for (int c = 0; c < 4; c++) step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    for (int k = 0; k < 10 && !bus.out_valid; k++) step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge pclk);
    check("rst_mid_valid",    64'(bus.out_valid), 64'd0);
    check("rst_mid_overflow", 64'(bus.overflow),  64'd0);
    rst = 1'b0;
    @(negedge pclk);
    for (int c = 0; c < 4; c++) step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    drain(40, 1'b0);
    check("rst_after_bx", 64'(first_bx), 64'd0);
    check("rst_after_by", 64'(first_by), 64'd0);

    // Start of frame after a partial block
    for (int c = 0; c < 2; c++) step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    n_xfer = 0;
    for (int c = 0; c < 4; c++) step(1'b1, rnd64(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    drain(40, 1'b0);
    check("sof_words", 64'(n_xfer), 64'd4);
    check("sof_bx",    64'(first_bx), 64'd0);

    // Random valid/ready traffic
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rnd64(), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, 1'b0);
    drain(100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
